// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for the unified memory arbiter: data-cache port, instruction-cache
// port and the single-ported backing-memory port.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (caches + memory).
interface unified_mem_arbiter_if;
  logic         d_read;
  logic         d_write;
  logic [5:0]   d_address;
  logic [31:0]  d_writedata;
  logic [31:0]  d_readdata;
  logic         d_busywait;

  logic         i_read;
  logic [5:0]   i_address;
  logic [127:0] i_readdata;
  logic         i_busywait;

  logic         m_read;
  logic         m_write;
  logic [8:0]   m_address;
  logic [31:0]  m_writedata;
  logic [31:0]  m_readdata;
  logic         m_busywait;

  modport slave (
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    input  i_read, i_address,
    output i_readdata, i_busywait,
    output m_read, m_write, m_address, m_writedata,
    input  m_readdata, m_busywait
  );

  modport master (
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    output i_read, i_address,
    input  i_readdata, i_busywait,
    input  m_read, m_write, m_address, m_writedata,
    output m_readdata, m_busywait
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one word-wide backing memory between a
// data cache (single-word block access) and an instruction cache (4-word
// block fetch).
//
// Optional feature macro ROUND_ROBIN_EN: when defined, simultaneous requests
// seen in IDLE are granted alternately; otherwise the data port always wins.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate pending requests
// D_ACC   | data word access in flight on the memory port
// I_FETCH | instruction beat in flight (beat counter selects the word)
// GAP     | one idle memory cycle between instruction beats
// D_DONE  | data result valid, D_BUSYWAIT released for one cycle
// I_DONE  | fetched block valid, I_BUSYWAIT released for one cycle
module unified_mem_arbiter (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ACC   = 3'd1,
    I_FETCH = 3'd2,
    GAP     = 3'd3,
    D_DONE  = 3'd4,
    I_DONE  = 3'd5
  } state_t;

  state_t       state, state_nxt;
  logic [1:0]   beat, beat_nxt;

  logic         m_read_q, m_read_nxt;
  logic         m_write_q, m_write_nxt;
  logic [8:0]   m_address_q, m_address_nxt;
  logic [31:0]  m_writedata_q, m_writedata_nxt;

  logic [31:0]  d_readdata_q;
  logic [127:0] i_readdata_q;
  logic [95:0]  stage;

  // seen_busy: the current beat has observed M_BUSYWAIT high at least once,
  // so a low busywait now really means "word finished".
  logic         seen_busy;
  // lost: the granted requester dropped its request during this transaction.
  logic         lost;

  logic         d_req, i_req;
  logic         beat_done;
  logic         d_lost_now, i_lost_now;
  logic         pick_d;

  assign d_req      = bus.d_read | bus.d_write;
  assign i_req      = bus.i_read;
  assign beat_done  = (m_read_q | m_write_q) & ~bus.m_busywait & seen_busy;
  assign d_lost_now = lost | ~d_req;
  assign i_lost_now = lost | ~i_req;

`ifdef ROUND_ROBIN_EN
  // rr_ptr: 0 favours data, 1 favours instruction on a same-cycle conflict.
  logic rr_ptr;
  logic contested;

  assign pick_d = d_req & (~i_req | ~rr_ptr);

  // Remember whether the grant was contested; flip priority once it completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= 1'b0;
      contested <= 1'b0;
    end else begin
      if (state == IDLE)
        contested <= d_req & i_req;
      if ((state == D_DONE || state == I_DONE) && contested)
        rr_ptr <= ~rr_ptr;
    end
  end
`else
  assign pick_d = d_req;
`endif

  // State and beat counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      beat  <= 2'd0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Next-state logic and next values of the registered memory-port outputs.
  always_comb begin
    state_nxt       = state;
    beat_nxt        = beat;
    m_read_nxt      = m_read_q;
    m_write_nxt     = m_write_q;
    m_address_nxt   = m_address_q;
    m_writedata_nxt = m_writedata_q;

    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt       = D_ACC;
          m_read_nxt      = bus.d_read;
          m_write_nxt     = bus.d_write;
          m_address_nxt   = {1'b1, 2'b00, bus.d_address};
          m_writedata_nxt = bus.d_writedata;
        end else if (i_req) begin
          state_nxt     = I_FETCH;
          beat_nxt      = 2'd0;
          m_read_nxt    = 1'b1;
          m_write_nxt   = 1'b0;
          m_address_nxt = {1'b0, bus.i_address, 2'b00};
        end
      end

      D_ACC: begin
        if (beat_done) begin
          m_read_nxt  = 1'b0;
          m_write_nxt = 1'b0;
          state_nxt   = d_lost_now ? IDLE : D_DONE;
        end
      end

      I_FETCH: begin
        if (beat_done) begin
          m_read_nxt = 1'b0;
          if (i_lost_now)
            state_nxt = IDLE;
          else if (beat == 2'd3)
            state_nxt = I_DONE;
          else begin
            state_nxt = GAP;
            beat_nxt  = beat + 2'd1;
          end
        end
      end

      GAP: begin
        if (i_lost_now) begin
          state_nxt = IDLE;
        end else begin
          // Block address is kept from the first beat; only the word index moves.
          state_nxt     = I_FETCH;
          m_read_nxt    = 1'b1;
          m_address_nxt = {m_address_q[8:2], beat};
        end
      end

      D_DONE:  state_nxt = IDLE;
      I_DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-port output registers, beat tracking and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= 9'd0;
      m_writedata_q <= 32'd0;
      seen_busy     <= 1'b0;
      lost          <= 1'b0;
      d_readdata_q  <= 32'd0;
      i_readdata_q  <= 128'd0;
      stage         <= 96'd0;
    end else begin
      m_read_q      <= m_read_nxt;
      m_write_q     <= m_write_nxt;
      m_address_q   <= m_address_nxt;
      m_writedata_q <= m_writedata_nxt;

      if (beat_done || !(m_read_q || m_write_q))
        seen_busy <= 1'b0;
      else if (bus.m_busywait)
        seen_busy <= 1'b1;

      if (state == IDLE)
        lost <= 1'b0;
      else if ((state == D_ACC && !d_req) ||
               ((state == I_FETCH || state == GAP) && !i_req))
        lost <= 1'b1;

      if (state == D_ACC && beat_done && m_read_q && !d_lost_now)
        d_readdata_q <= bus.m_readdata;

      // Words 0..2 are staged so I_READDATA only changes on a full block.
      if (state == I_FETCH && beat_done) begin
        case (beat)
          2'd0: stage[31:0]  <= bus.m_readdata;
          2'd1: stage[63:32] <= bus.m_readdata;
          2'd2: stage[95:64] <= bus.m_readdata;
          default: begin
            if (!i_lost_now)
              i_readdata_q <= {bus.m_readdata, stage};
          end
        endcase
      end
    end
  end

  assign bus.m_read      = m_read_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_address   = m_address_q;
  assign bus.m_writedata = m_writedata_q;
  assign bus.d_readdata  = d_readdata_q;
  assign bus.i_readdata  = i_readdata_q;
  assign bus.d_busywait  = d_req & (state != D_DONE);
  assign bus.i_busywait  = i_req & (state != I_DONE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter with a fixed-latency word memory.
module tb_unified_mem_arbiter;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Backing memory: busywait high for the first LAT cycles of each access.
  logic [31:0] mem [0:511];
  int          mcnt = 0;
  int          wr_cnt = 0;
  logic [8:0]  wr_addr = 9'd0;
  logic [31:0] wr_data = 32'd0;

  assign bus.m_busywait = (bus.m_read | bus.m_write) && (mcnt < LAT);
  assign bus.m_readdata = bus.m_read ? mem[bus.m_address] : 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= 0;
    end else if (bus.m_read | bus.m_write) begin
      if (mcnt >= LAT) begin
        mcnt <= 0;
        if (bus.m_write) begin
          wr_cnt  <= wr_cnt + 1;
          wr_addr <= bus.m_address;
          wr_data <= bus.m_writedata;
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Beat monitor: logs start address of each access and idle cycles before it.
  logic [8:0] alog [0:63];
  int         glog [0:63];
  int         acnt = 0;
  int         idle_run = 0;
  logic       prev_act = 1'b0;

  always @(negedge clk) begin
    if (bus.m_read | bus.m_write) begin
      if (!prev_act && acnt < 64) begin
        alog[acnt] <= bus.m_address;
        glog[acnt] <= idle_run;
        acnt       <= acnt + 1;
        idle_run   <= 0;
      end
    end else begin
      idle_run <= idle_run + 1;
    end
    prev_act <= bus.m_read | bus.m_write;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise a data write and an instruction fetch together; serve both.
  task automatic conflict_pair(output int dd, output int id);
    bit dact, iact;
    dd = -1;
    id = -1;
    bus.d_address   = 6'h07;
    bus.d_writedata = 32'h12345678;
    bus.i_address   = 6'h01;
    bus.d_write     = 1'b1;
    bus.i_read      = 1'b1;
    dact = 1'b1;
    iact = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (dact && !bus.d_busywait) begin
        dd = k;
        bus.d_write = 1'b0;
        dact = 1'b0;
      end
      if (iact && !bus.i_busywait) begin
        id = k;
        bus.i_read = 1'b0;
        iact = 1'b0;
      end
      if (!dact && !iact) break;
    end
    bus.d_write = 1'b0;
    bus.i_read  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dd, id, base, wbase;

    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_address = 6'd0;
    bus.d_writedata = 32'd0;
    bus.i_read = 1'b0;
    bus.i_address = 6'd0;
    for (int a = 0; a < 512; a++) mem[a] = 32'd0;
    mem[9'h105] = 32'hCAFEBABE;
    mem[9'h109] = 32'hDEADBEEF;
    mem[9'h008] = 32'h00000011;
    mem[9'h009] = 32'h00000022;
    mem[9'h00A] = 32'h00000033;
    mem[9'h00B] = 32'h00000044;
    mem[9'h004] = 32'hA0A0A0A0;
    mem[9'h005] = 32'hA1A1A1A1;
    mem[9'h006] = 32'hA2A2A2A2;
    mem[9'h007] = 32'hA3A3A3A3;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_m_read",      128'(bus.m_read),      128'(1'b0));
    chk("rst_m_write",     128'(bus.m_write),     128'(1'b0));
    chk("rst_m_address",   128'(bus.m_address),   128'(9'h000));
    chk("rst_m_writedata", 128'(bus.m_writedata), 128'(32'h0));
    chk("rst_d_readdata",  128'(bus.d_readdata),  128'(32'h0));
    chk("rst_i_readdata",  bus.i_readdata,        128'h0);
    chk("rst_i_busy_idle", 128'(bus.i_busywait),  128'(1'b0));
    bus.d_read = 1'b1;
    #1;
    chk("rst_d_busy_follow", 128'(bus.d_busywait), 128'(1'b1));
    bus.d_read = 1'b0;
    #1;
    chk("rst_d_busy_drop", 128'(bus.d_busywait), 128'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Data read, latency 5: done cycle L+2 = 7
    bus.d_address = 6'h05;
    bus.d_read = 1'b1;
    #1;
    chk("d_busy_on_req", 128'(bus.d_busywait), 128'(1'b1));
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("d_m_read",    128'(bus.m_read),    128'(1'b1));
        chk("d_m_address", 128'(bus.m_address), 128'(9'h105));
      end
      if (!bus.d_busywait) begin
        n = k;
        break;
      end
    end
    chk("d_done_cycle", 128'(n), 128'(7));
    chk("d_readdata",   128'(bus.d_readdata), 128'(32'hCAFEBABE));
    @(negedge clk);
    chk("d_busy_one_cycle", 128'(bus.d_busywait), 128'(1'b1));
    bus.d_read = 1'b0;
    #1;
    chk("d_busy_released", 128'(bus.d_busywait), 128'(1'b0));
    repeat (2) @(negedge clk);

    // Instruction fetch of block 2
    #1;
    base = acnt;
    bus.i_address = 6'h02;
    bus.i_read = 1'b1;
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!bus.i_busywait) begin
        n = k;
        break;
      end
    end
    chk("i_fetch_done", 128'(n > 0), 128'(1'b1));
    chk("i_readdata", bus.i_readdata, 128'h00000044_00000033_00000022_00000011);
    bus.i_read = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("i_beat_count", 128'(acnt - base), 128'(4));
    for (int b = 0; b < 4; b++) begin
      chk("i_beat_addr", 128'(alog[base + b]), 128'(9'h008 + 9'(b)));
      if (b > 0) chk("i_gap_len", 128'(glog[base + b]), 128'(1));
    end
    chk("d_readdata_hold", 128'(bus.d_readdata), 128'(32'hCAFEBABE));

    // Simultaneous data write + fetch, first pair: data wins in both builds
    wbase = wr_cnt;
    conflict_pair(dd, id);
    chk("p1_data_cycle",  128'(dd), 128'(7));
    chk("p1_data_first",  128'(dd > 0 && id > dd), 128'(1'b1));
    chk("p1_write_count", 128'(wr_cnt - wbase), 128'(1));
    chk("p1_write_addr",  128'(wr_addr), 128'(9'h107));
    chk("p1_write_data",  128'(wr_data), 128'(32'h12345678));
    chk("p1_i_readdata",  bus.i_readdata, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);

    // Second identical pair: order depends on the arbitration policy
    conflict_pair(dd, id);
`ifdef ROUND_ROBIN_EN
    chk("p2_instr_first", 128'(id > 0 && dd > id), 128'(1'b1));
`else
    chk("p2_data_first",  128'(dd > 0 && id > dd), 128'(1'b1));
`endif
    chk("p2_write_count", 128'(wr_cnt - wbase), 128'(2));

    // Data request dropped mid-beat: beat finishes, result discarded
    #1;
    base = acnt;
    bus.d_address = 6'h09;
    bus.d_read = 1'b1;
    repeat (2) @(negedge clk);
    bus.d_read = 1'b0;
    #1;
    chk("drop_busy_low", 128'(bus.d_busywait), 128'(1'b0));
    @(negedge clk);
    chk("drop_beat_continues", 128'(bus.m_read), 128'(1'b1));
    repeat (10) @(negedge clk);
    chk("drop_m_read_idle",   128'(bus.m_read), 128'(1'b0));
    chk("drop_discarded",     128'(bus.d_readdata), 128'(32'hCAFEBABE));
    bus.d_read = 1'b1;
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!bus.d_busywait) begin
        n = k;
        break;
      end
    end
    chk("drop_retry_cycle", 128'(n), 128'(7));
    chk("drop_retry_data",  128'(bus.d_readdata), 128'(32'hDEADBEEF));
    bus.d_read = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during fetch beat 2, then fetch restarts from beat 0
    #1;
    base = acnt;
    bus.i_address = 6'h02;
    bus.i_read = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      #1;
      if (acnt > base + 2) break;
    end
    chk("rst_mid_beat2_addr", 128'(alog[base + 2]), 128'(9'h00A));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_m_read",      128'(bus.m_read),      128'(1'b0));
    chk("rst_mid_m_address",   128'(bus.m_address),   128'(9'h000));
    chk("rst_mid_m_writedata", 128'(bus.m_writedata), 128'(32'h0));
    chk("rst_mid_i_readdata",  bus.i_readdata,        128'h0);
    chk("rst_mid_d_readdata",  128'(bus.d_readdata),  128'(32'h0));
    chk("rst_mid_i_busy",      128'(bus.i_busywait),  128'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    base = acnt;
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!bus.i_busywait) begin
        n = k;
        break;
      end
    end
    chk("restart_done",      128'(n > 0), 128'(1'b1));
    chk("restart_beat0",     128'(alog[base]), 128'(9'h008));
    chk("restart_readdata",  bus.i_readdata, 128'h00000044_00000033_00000022_00000011);
    bus.i_read = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
